// File: rtl/hub_crossbar_router_pkg.sv
// Shared constants for the hub crossbar router: default sizes, the
// broadcast destination code and the destination-field extraction macro.
`ifndef HCR_DEST
`define HCR_DEST(w, cw, dw) w[(cw)-1 -: (dw)]
`endif

package hub_crossbar_router_pkg;

  localparam int NUM_CHANNELS_DEF  = 5;
  localparam int CHANNEL_WIDTH_DEF = 64;
  localparam int DEST_WIDTH_DEF    = 8;

  localparam logic [DEST_WIDTH_DEF-1:0] DEST_BCAST = '1;

  function automatic int ch_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int CH_IDX_W = ch_idx_w(NUM_CHANNELS_DEF);

endpackage

// File: rtl/hub_crossbar_router_if.sv
// Packed per-channel rx/tx valid/ready bundle between the hub FIFOs
// and the crossbar router.
interface hub_crossbar_router_if
  import hub_crossbar_router_pkg::*;
#(
  parameter int NUM_CHANNELS  = NUM_CHANNELS_DEF,
  parameter int CHANNEL_WIDTH = CHANNEL_WIDTH_DEF
) ();

  logic [CHANNEL_WIDTH*NUM_CHANNELS-1:0] rx_data;
  logic [NUM_CHANNELS-1:0]               rx_valid;
  logic [NUM_CHANNELS-1:0]               rx_ready;
  logic [CHANNEL_WIDTH*NUM_CHANNELS-1:0] tx_data;
  logic [NUM_CHANNELS-1:0]               tx_valid;
  logic [NUM_CHANNELS-1:0]               tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid
  );

endinterface

// File: rtl/hub_crossbar_router_rr_arbiter.sv
// Round-robin arbiter: first request at or after ptr wins, one-hot grant
// plus its index. Reusable by other hubs.
module hub_crossbar_router_rr_arbiter
  import hub_crossbar_router_pkg::*;
#(
  parameter int N  = NUM_CHANNELS_DEF,
  parameter int IW = CH_IDX_W
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_vld
);

  always_comb begin
    int            sum;
    logic [IW-1:0] idx;
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    sum     = 0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      sum = int'(ptr) + k;
      idx = IW'((sum >= N) ? sum - N : sum);
      if (!gnt_vld && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        gnt_vld  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hub_crossbar_router.sv
// Destination-decoded N-port crossbar with per-output holding registers.
// Optional ROUTER_DROP_COUNTER_EN adds a saturating illegal-dest counter.
module hub_crossbar_router
  import hub_crossbar_router_pkg::*;
#(
  parameter int NUM_CHANNELS  = NUM_CHANNELS_DEF,
  parameter int CHANNEL_WIDTH = CHANNEL_WIDTH_DEF,
  parameter int DEST_WIDTH    = DEST_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  hub_crossbar_router_if.slave bus,
  output logic                 router_busy
`ifdef ROUTER_DROP_COUNTER_EN
  ,
  output logic [15:0]          drop_count
`endif
);

  localparam int N  = NUM_CHANNELS;
  localparam int CW = CHANNEL_WIDTH;
  localparam int DW = DEST_WIDTH;
  localparam int IW = ch_idx_w(NUM_CHANNELS);

  logic [N-1:0][CW-1:0] rx_w;
  logic [N-1:0][CW-1:0] data_q, data_d;
  logic [N-1:0][DW-1:0] dest;
  logic [N-1:0][N-1:0]  tgt;
  logic [N-1:0]         ill, free, req, gnt, load;
  logic [N-1:0]         vld_q, vld_d;
  logic [IW-1:0]        gidx, rr_ptr_q, rr_ptr_d;
  logic                 gvld;

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign rx_w[i] = bus.rx_data[CW*i +: CW];
    assign dest[i] = `HCR_DEST(rx_w[i], CW, DW);
    assign bus.tx_data[CW*i +: CW] = data_q[i];
  end

  assign bus.tx_valid = vld_q;
  assign bus.rx_ready = gnt;
  assign router_busy  = (|bus.rx_valid) || (|vld_q);

  always_comb begin
    tgt = '0;
    ill = '0;
    for (int i = 0; i < N; i++) begin
      if (dest[i] == {DW{1'b1}}) begin
        for (int j = 1; j < N; j++) tgt[i][j] = (j != i);
      end else if (int'(dest[i]) < N) begin
        for (int j = 0; j < N; j++) tgt[i][j] = (int'(dest[i]) == j);
      end else begin
        ill[i] = 1'b1;
      end
    end
  end

  // A word is grantable only when its whole target set can load this edge.
  always_comb begin
    free = ~vld_q | bus.tx_ready;
    req  = '0;
    for (int i = 0; i < N; i++) begin
      req[i] = bus.rx_valid[i] && !reset &&
               (ill[i] || ((tgt[i] & ~free) == '0));
    end
  end

  hub_crossbar_router_rr_arbiter #(
    .N  (N),
    .IW (IW)
  ) u_arb (
    .req     (req),
    .ptr     (rr_ptr_q),
    .gnt     (gnt),
    .gnt_idx (gidx),
    .gnt_vld (gvld)
  );

  always_comb begin
    load     = gvld ? tgt[gidx] : '0;
    vld_d    = vld_q;
    data_d   = data_q;
    rr_ptr_d = rr_ptr_q;
    for (int j = 0; j < N; j++) begin
      if (load[j]) begin
        vld_d[j]  = 1'b1;
        data_d[j] = rx_w[gidx];
      end else if (bus.tx_ready[j]) begin
        vld_d[j] = 1'b0;
      end
    end
    if (gvld) rr_ptr_d = (int'(gidx) == N - 1) ? '0 : gidx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= '0;
      data_q   <= '0;
      rr_ptr_q <= '0;
    end else begin
      vld_q    <= vld_d;
      data_q   <= data_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

`ifdef ROUTER_DROP_COUNTER_EN
  logic [15:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (gvld && ill[gidx] && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_hub_crossbar_router.sv
// Scoreboard bench for hub_crossbar_router: directed words per channel,
// expected words queued per output and checked by a negedge monitor.
module tb_hub_crossbar_router;
  import hub_crossbar_router_pkg::*;

  localparam int NCH = 5;

  logic clk;
  logic reset;
  logic router_busy;
`ifdef ROUTER_DROP_COUNTER_EN
  logic [15:0] drop_count;
`endif

  hub_crossbar_router_if #(.NUM_CHANNELS(NCH), .CHANNEL_WIDTH(64)) bus ();

  hub_crossbar_router dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .router_busy (router_busy)
`ifdef ROUTER_DROP_COUNTER_EN
    ,
    .drop_count  (drop_count)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vectors = 0;
  int miscompares = 0;

  logic [63:0]    pend  [NCH][$];
  logic [63:0]    exp_q [NCH][$];
  logic [NCH-1:0] acc;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] txw(input int j);
    return bus.tx_data[64*j +: 64];
  endfunction

  function automatic logic [63:0] rr_word(input int c, input int r);
    return {8'h00, 32'h0, 8'(c), 16'(r)};
  endfunction

  function automatic bit idle();
    for (int c = 0; c < NCH; c++)
      if (pend[c].size() != 0 || exp_q[c].size() != 0) return 1'b0;
    return bus.tx_valid == '0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!idle() && n < budget) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (!idle()) begin
      miscompares++;
      $display("FAIL %s drain: not idle after %0d cycles, required idle",
               name, budget);
    end
  endtask

  // Driver: presents the head of each channel queue, pops on acceptance.
  initial begin
    bus.rx_valid = '0;
    bus.rx_data  = '0;
    forever begin
      @(posedge clk);
      for (int c = 0; c < NCH; c++)
        if (acc[c] && pend[c].size() > 0) void'(pend[c].pop_front());
      #2;
      for (int c = 0; c < NCH; c++) begin
        if (pend[c].size() > 0) begin
          bus.rx_valid[c]          = 1'b1;
          bus.rx_data[64*c +: 64]  = pend[c][0];
        end else begin
          bus.rx_valid[c] = 1'b0;
        end
      end
    end
  end

  // Monitor: every output transfer must match the head of its queue.
  initial begin
    acc = '0;
    forever begin
      @(negedge clk);
      acc = bus.rx_valid & bus.rx_ready;
      if (!reset) begin
        for (int j = 0; j < NCH; j++) begin
          if (bus.tx_valid[j] && bus.tx_ready[j]) begin
            if (exp_q[j].size() == 0) begin
              vectors++;
              miscompares++;
              $display("FAIL tx%0d unexpected: got %0h required none",
                       j, txw(j));
            end else begin
              chk($sformatf("tx%0d data", j), txw(j), exp_q[j].pop_front());
            end
          end
        end
      end
    end
  end

  initial begin
    logic [63:0] w1, wa, wb, c1, c2, wd, we, wf;
    logic [63:0] bad [2];
    int          order [4];
    int          cnt;
    int          n;
    w1 = 64'h03000000_0000ABCD;
    wa = 64'h04000000_0000AAAA;
    wb = {DEST_BCAST, 56'h0000_0000_00BBBB};
    c1 = 64'h03000000_0000C001;
    c2 = 64'h03000000_0000C002;
    wd = 64'h02000000_0000DDDD;
    we = 64'h01000000_0000EEEE;
    wf = 64'h01000000_0000FFFF;
    bad[0] = 64'h07000000_00000D07;
    bad[1] = 64'h05000000_00000D05;
    order = '{3, 4, 1, 2};

    reset        = 1'b1;
    bus.tx_ready = '1;
    tick();
    tick();

    // Reset state with a word already waiting, then single-dest delivery
    pend[0].push_back(w1);
    exp_q[3].push_back(w1);
    @(negedge clk);
    chk("rst rx_ready", 64'(bus.rx_ready), 64'h0);
    chk("rst tx_valid", 64'(bus.tx_valid), 64'h0);
    chk("rst tx_data", 64'(|bus.tx_data), 64'h0);
    chk("rst busy", 64'(router_busy), 64'h1);
`ifdef ROUTER_DROP_COUNTER_EN
    chk("rst drop_count", 64'(drop_count), 64'h0);
`endif
    tick();
    reset = 1'b0;
    @(negedge clk);
    chk("t1 grant", 64'(bus.rx_ready), 64'h01);
    @(negedge clk);
    chk("t1 tx_valid", 64'(bus.tx_valid), 64'h08);
    wait_idle("t1", 20);

    // Broadcast stalls behind a held word on channel 4
    tick();
    bus.tx_ready[4] = 1'b0;
    pend[0].push_back(wa);
    exp_q[4].push_back(wa);
    repeat (3) tick();
    pend[2].push_back(wb);
    exp_q[1].push_back(wb);
    exp_q[3].push_back(wb);
    exp_q[4].push_back(wb);
    repeat (3) begin
      @(negedge clk);
      chk("t2 stall rx_ready2", 64'(bus.rx_ready[2]), 64'h0);
      chk("t2 hold tx_valid4", 64'(bus.tx_valid[4]), 64'h1);
      chk("t2 hold tx_data4", txw(4), wa);
    end
    tick();
    bus.tx_ready[4] = 1'b1;
    @(negedge clk);
    chk("t2 grant", 64'(bus.rx_ready), 64'h04);
    @(negedge clk);
    chk("t2 bcast tx_valid", 64'(bus.tx_valid), 64'h1A);
    wait_idle("t2", 20);

    // Four inputs to output 0: rotation from ptr 3, no bubbles
    tick();
    for (int r = 0; r < 3; r++) begin
      for (int c = 1; c < NCH; c++) pend[c].push_back(rr_word(c, r));
      for (int k = 0; k < 4; k++) exp_q[0].push_back(rr_word(order[k], r));
    end
    n = 0;
    while (!bus.tx_valid[0] && n < 10) begin
      @(negedge clk);
      n++;
    end
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.tx_valid[0]) cnt++;
      @(negedge clk);
    end
    chk("t3 back-to-back", 64'(cnt), 64'd12);
    wait_idle("t3", 30);

    // Backpressure holds the first word; second delivered after release
    tick();
    bus.tx_ready[3] = 1'b0;
    pend[0].push_back(c1);
    pend[0].push_back(c2);
    exp_q[3].push_back(c1);
    exp_q[3].push_back(c2);
    repeat (2) tick();
    repeat (3) begin
      @(negedge clk);
      chk("t4 hold tx_valid3", 64'(bus.tx_valid[3]), 64'h1);
      chk("t4 hold tx_data3", txw(3), c1);
      chk("t4 stall rx_ready0", 64'(bus.rx_ready[0]), 64'h0);
    end
    tick();
    bus.tx_ready[3] = 1'b1;
    wait_idle("t4", 20);

    // Illegal destinations are accepted and dropped
    for (int k = 0; k < 2; k++) begin
      tick();
      pend[k+1].push_back(bad[k]);
      @(negedge clk);
      chk($sformatf("t5 ill%0d grant", k), 64'(bus.rx_ready), 64'(1 << (k+1)));
      @(negedge clk);
      chk($sformatf("t5 ill%0d tx_valid", k), 64'(bus.tx_valid), 64'h0);
`ifdef ROUTER_DROP_COUNTER_EN
      chk($sformatf("t5 ill%0d drop_count", k), 64'(drop_count), 64'(k + 1));
`endif
    end
    wait_idle("t5", 20);

    // Reset discards a held word and restarts the pointer at 0
    tick();
    bus.tx_ready[2] = 1'b0;
    pend[0].push_back(wd);
    exp_q[2].push_back(wd);
    repeat (2) tick();
    @(negedge clk);
    chk("t6 held tx_valid2", 64'(bus.tx_valid[2]), 64'h1);
    tick();
    reset = 1'b1;
    exp_q[2].delete();
    tick();
    @(negedge clk);
    chk("t6 rst tx_valid", 64'(bus.tx_valid), 64'h0);
    chk("t6 rst busy", 64'(router_busy), 64'h0);
    chk("t6 rst tx_data", 64'(|bus.tx_data), 64'h0);
    tick();
    reset        = 1'b0;
    bus.tx_ready = '1;
    pend[2].push_back(we);
    pend[0].push_back(wf);
    exp_q[1].push_back(wf);
    exp_q[1].push_back(we);
    wait_idle("t6", 20);

    repeat (2) tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
